pipe_stage_buf: RTL
===================

// Module: pipe_stage_buf
//
// PURPOSE
//   Parametrised elastic pipeline stage that replaces the fixed IF/ID/EX/MEM
//   stage registers. It carries one packed stage struct (flattened to WIDTH
//   bits) and supports valid/ready handshake, DEPTH-entry buffering, flush,
//   and bubble insertion of a programmable NOP payload. Built-in counters
//   report stall and bubble cycles for pipeline performance analysis.
//
// PARAMETERS
//   WIDTH         64       payload bits; instantiate with $bits(<stage struct>)
//   DEPTH         2        entries, >=1; DEPTH>=2 needed for 1 item/cycle throughput
//   BUBBLE_VALUE  '0       WIDTH-bit payload driven on out_data when out_valid=0
//   CNT_W         32       width of the stall/bubble performance counters
//
// PORTS
//   clock          in   1                 rising-edge clock
//   reset          in   1                 synchronous, active-high reset
//   flush          in   1                 discard all held entries (branch/exception)
//   in_valid       in   1                 upstream has a payload
//   in_ready       out  1                 stage can accept; = (count != DEPTH)
//   in_data        in   WIDTH             upstream payload
//   out_valid      out  1                 head entry present
//   out_ready      in   1                 downstream consumes head this cycle
//   out_data       out  WIDTH             head payload, or BUBBLE_VALUE if empty
//   count          out  $clog2(DEPTH+1)   entries held
//   stall_cycles   out  CNT_W             cycles with out_valid && !out_ready
//   bubble_cycles  out  CNT_W             cycles with !out_valid && out_ready
//
// BEHAVIOUR
//   - Reset (sync, active-high; overrides flush and all handshakes): count=0,
//     rd/wr pointers=0, out_valid=0, out_data=BUBBLE_VALUE, in_ready=1,
//     both counters=0. Storage contents are don't-care.
//   - Push = in_valid && in_ready; pop = out_valid && out_ready; both
//     evaluated on the same edge. count' = count + push - pop.
//   - in_ready depends only on registered count; there is no combinational
//     path from out_ready to in_ready. When full, a push is refused even if
//     pop fires in the same cycle.
//   - No bypass: data pushed at edge N appears on out_data after edge N,
//     i.e. latency 1 cycle when empty. out_valid = (count != 0).
//   - out_data = mem[rd_ptr] when out_valid, else BUBBLE_VALUE. out_data is
//     stable while out_valid && !out_ready.
//   - Pointers advance modulo DEPTH: at DEPTH-1 they wrap to 0. This must
//     hold for non-power-of-2 DEPTH. FIFO order is strict.
//   - DEPTH=1 behaves as a stallable pipeline register at half throughput.
//   - flush: at the next edge count=0, ptrs=0, out_valid=0. A push asserted
//     in the flush cycle is dropped. A pop in the flush cycle is still a
//     valid handshake for the downstream stage. Counters are not cleared.
//   - Counters update every non-reset cycle from pre-edge out_valid and
//     out_ready, and saturate at 2^CNT_W-1 (no wrap).
//   - in_valid when !in_ready is a legal no-op. in_data is ignored unless
//     push fires.
//
// TESTING
//   1 Reset, then idle 3 cycles -> out_valid=0, out_data=BUBBLE_VALUE,
//     in_ready=1, count=0, counters=0.
//   2 DEPTH=2, out_ready=1, push 0xA,0xB,0xC at edges 1..3 -> out_data
//     0xA,0xB,0xC after edges 1..3, in_ready=1 throughout, count<=1.
//   3 DEPTH=2, out_ready=0, in_valid=1 with 0x1,0x2,0x3 -> only 0x1 and 0x2
//     accepted, in_ready=0 at count=2, stall_cycles increments per cycle.
//     Then out_ready=1 -> 0x1 then 0x2, and 0x3 is accepted after the first pop.
//   4 count=2, assert flush with in_valid=1 (0xF) -> next cycle count=0,
//     out_valid=0, 0xF never emerges, stall/bubble counts retained.
//   5 DEPTH=3, random valid/ready for 1000 cycles vs scoreboard -> no
//     loss/dup/reorder, pointers wrap 2->0, count never >3.
//   6 Mid-stream reset with flush=1 and in_valid=1 -> reset state exactly as
//     in (1). Separately, CNT_W=4 with 20 stall cycles -> stall_cycles holds 15.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: DEPTH-entry circular buffer with valid/ready on both sides,
// flush, a programmable bubble payload, and saturating stall/bubble counters.
module pipe_stage_buf #(
    parameter int                 WIDTH        = 64,
    parameter int                 DEPTH        = 2,
    parameter logic [WIDTH-1:0]   BUBBLE_VALUE = '0,
    parameter int                 CNT_W        = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNT_W-1:0]             stall_cycles,
    output logic [CNT_W-1:0]             bubble_cycles
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_bubble;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Handshake: a transfer happens on an edge where valid && ready; ready never
    // looks at valid, and in_ready is a function of the registered count only,
    // so a full stage refuses a push even while its head is being popped.
    assign w_in_ready  = (r_count != CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    // Modulo-DEPTH increment; works for any DEPTH, not just powers of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (w_push && !flush && !reset) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Counters survive flush and stick at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall  <= '0;
            r_bubble <= '0;
        end else begin
            if (w_out_valid && !out_ready && (r_stall != '1)) begin
                r_stall <= r_stall + CNT_W'(1);
            end
            if (!w_out_valid && out_ready && (r_bubble != '1)) begin
                r_bubble <= r_bubble + CNT_W'(1);
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = w_out_valid;
    assign out_data      = w_out_valid ? r_mem[r_rd_ptr] : BUBBLE_VALUE;
    assign count         = r_count;
    assign stall_cycles  = r_stall;
    assign bubble_cycles = r_bubble;

endmodule
